seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: tracks a multiplexed 4-digit 7-segment scan and publishes each frame as binary and BCD.
module seg_scan_decoder (
    input  logic        dclk18,
    input  logic        rst,
    input  logic [3:0]  an_in,
    input  logic [6:0]  seg_in,
    output logic [13:0] value,
    output logic [15:0] digits,
    output logic        valid,
    output logic        err,
    output logic        locked
);
    typedef enum logic {SYNC, TRACK} state_t;
    state_t      state_q, state_d;
    logic [1:0]  exp_q, exp_d;
    logic [11:0] buf_q;
    logic [15:0] conv_q, pdig_q;
    logic [13:0] acc_q, acc_base, acc_next;
    logic [3:0]  conv_nib;
    logic [1:0]  cnt_q;
    logic        busy_q, pend_q;
    logic        an_ok, seg_ok, store, copy, err_d;
    logic [1:0]  pos;
    logic [3:0]  dig;
    assign an_ok = an_in == 4'b1110 || an_in == 4'b1101 || an_in == 4'b1011 || an_in == 4'b0111;
    assign pos = {~an_in[3] | ~an_in[2], ~an_in[3] | ~an_in[1]};
    assign locked = state_q == TRACK;
    always_comb begin
        seg_ok = 1'b1;
        dig = 4'd0;
        case (seg_in)
            7'b1000000: dig = 4'd0;
            7'b1111001: dig = 4'd1;
            7'b0100100: dig = 4'd2;
            7'b0110000: dig = 4'd3;
            7'b0011001: dig = 4'd4;
            7'b0010010: dig = 4'd5;
            7'b0000010: dig = 4'd6;
            7'b1111000: dig = 4'd7;
            7'b0000000: dig = 4'd8;
            7'b0010000: dig = 4'd9;
            default:    seg_ok = 1'b0;
        endcase
    end
    // Violations drop to SYNC without capturing, so a violating 1110 never restarts a frame.
    always_comb begin
        state_d = state_q;
        exp_d = exp_q;
        store = 1'b0;
        err_d = 1'b0;
        if (state_q == SYNC) begin
            if (an_in == 4'b1110 && seg_ok) begin
                store = 1'b1;
                exp_d = 2'd1;
                state_d = TRACK;
            end
        end else if (an_ok && pos == exp_q && seg_ok) begin
            store = 1'b1;
            exp_d = exp_q + 2'd1;
        end else begin
            err_d = 1'b1;
            exp_d = 2'd0;
            state_d = SYNC;
        end
    end
    assign copy = store && state_q == TRACK && exp_q == 2'd3;
    // Digits are consumed most-significant first: position 3 down to position 0.
    assign conv_nib = conv_q[{~cnt_q, 2'b00} +: 4];
    assign acc_base = cnt_q == 2'd0 ? 14'd0 : acc_q;
    assign acc_next = (acc_base << 3) + (acc_base << 1) + {10'd0, conv_nib};
    always_ff @(posedge dclk18) begin
        if (rst) begin
            state_q <= SYNC;
            exp_q   <= 2'd0;
            buf_q   <= 12'd0;
            conv_q  <= 16'd0;
            pdig_q  <= 16'd0;
            acc_q   <= 14'd0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            value   <= 14'd0;
            digits  <= 16'd0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            err     <= err_d;
            if (err_d)
                buf_q <= 12'd0;
            else if (store)
                buf_q <= {pos == 2'd2 ? dig : buf_q[11:8],
                          pos == 2'd1 ? dig : buf_q[7:4],
                          pos == 2'd0 ? dig : buf_q[3:0]};
            if (busy_q)
                acc_q <= acc_next;
            pend_q <= busy_q && cnt_q == 2'd3;
            if (busy_q && cnt_q == 2'd3)
                pdig_q <= conv_q;
            // A new frame can only complete on the final step, so reloading then is safe.
            if (copy) begin
                conv_q <= {dig, buf_q};
                cnt_q  <= 2'd0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                cnt_q  <= cnt_q + 2'd1;
                busy_q <= cnt_q != 2'd3;
            end
            valid <= pend_q;
            if (pend_q) begin
                value  <= acc_q;
                digits <= pdig_q;
            end
        end
    end
endmodule
